// File: rtl/speed_pkg.sv
// Shared types and helpers for the speed-level controller: state encoding, level width,
// and button priority selection.
package speed_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_RAMP_UP   = 3'd1;
  localparam state_t ST_RAMP_DOWN = 3'd2;
  localparam state_t ST_HOLD      = 3'd3;
  localparam state_t ST_HALT      = 3'd4;

  localparam int unsigned MAX_LEVELS = 16;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } sel_t;

  function automatic int unsigned lvl_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Lowest index in 1..MAX_LEVELS-1 wins; bit 0 only selects level 0 when nothing else is set.
  function automatic sel_t prio_sel(logic [MAX_LEVELS-1:0] pressed);
    sel_t s;
    s.valid = |pressed;
    s.idx   = '0;
    for (int i = MAX_LEVELS - 1; i >= 1; i--) begin
      if (pressed[i]) s.idx = 4'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/speed_ramp_fsm_btn_edge.sv
// Registered rising-edge detector for a bank of synchronous, debounced buttons.
module btn_edge #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_btn,
  output logic [WIDTH-1:0] o_pressed
);

  logic [WIDTH-1:0] btn_q;
  logic             armed_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      btn_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      btn_q   <= i_btn;
      armed_q <= 1'b1;
    end
  end

  // Buttons already held when reset releases are absorbed by the first edge, not reported.
  assign o_pressed = i_btn & ~btn_q & {WIDTH{armed_q}};

endmodule

// File: rtl/speed_ramp_fsm.sv
// Speed-level controller: buttons pick a target level and the applied level ramps toward it
// one step per RAMP_TICKS ticks; halt forces level 0 and locks out the buttons.
module speed_ramp_fsm
  import speed_pkg::*;
#(
  parameter int unsigned NUM_LEVELS = 5,
  parameter int unsigned RAMP_TICKS = 4,
  parameter int unsigned LVL_W      = lvl_w(NUM_LEVELS)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [NUM_LEVELS-1:0] i_btn,
  input  logic                  i_tick,
  input  logic                  i_halt,
  output logic [LVL_W-1:0]      o_level,
  output logic [LVL_W-1:0]      o_target,
  output logic                  o_ramping,
  output logic                  o_halted
);

  localparam int unsigned CNT_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_TICKS - 1);

  state_t           state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [LVL_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_LEVELS-1:0] pressed;
  logic [MAX_LEVELS-1:0] pressed_ext;
  sel_t                  sel;
  logic [LVL_W-1:0]      sel_lvl;
  logic                  ramping;

  btn_edge #(
    .WIDTH(NUM_LEVELS)
  ) u_btn_edge (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_btn    (i_btn),
    .o_pressed(pressed)
  );

  function automatic state_t dir_state(logic [LVL_W-1:0] lvl, logic [LVL_W-1:0] tgt);
    if (lvl < tgt) return ST_RAMP_UP;
    if (lvl > tgt) return ST_RAMP_DOWN;
    return (tgt == '0) ? ST_IDLE : ST_HOLD;
  endfunction

  always_comb begin
    pressed_ext                 = '0;
    pressed_ext[NUM_LEVELS-1:0] = pressed;
    sel                         = prio_sel(pressed_ext);
    sel_lvl                     = LVL_W'(sel.idx);
  end

  assign ramping = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (i_halt) begin
      state_d  = ST_HALT;
      level_d  = '0;
      target_d = '0;
      cnt_d    = '0;
    end else if (state_q > ST_HALT) begin
      state_d  = ST_IDLE;
      level_d  = '0;
      target_d = '0;
      cnt_d    = '0;
    end else begin
      if (state_q == ST_HALT) state_d = ST_IDLE;
      // A retarget pre-empts any step that would complete this cycle.
      if (sel.valid) begin
        target_d = sel_lvl;
        cnt_d    = '0;
        state_d  = dir_state(level_q, sel_lvl);
      end else if (ramping && i_tick) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          level_d = (state_q == ST_RAMP_UP) ? level_q + LVL_W'(1) : level_q - LVL_W'(1);
          state_d = dir_state(level_d, target_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      level_q  <= '0;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_level   = level_q;
  assign o_target  = target_q;
  assign o_ramping = ramping;
  assign o_halted  = (state_q == ST_HALT);

endmodule

// File: tb/tb_speed_ramp_fsm.sv
// Scoreboard bench for speed_ramp_fsm: a 5-level/4-tick instance and a 16-level/1-tick instance.
module tb_speed_ramp_fsm;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [4:0]  btn5;
  logic        tick5, halt5;
  logic [2:0]  lvl5, tgt5;
  logic        ramp5, halted5;

  logic [15:0] btn16;
  logic        tick16, halt16;
  logic [3:0]  lvl16, tgt16;
  logic        ramp16, halted16;

  speed_ramp_fsm #(
    .NUM_LEVELS(5),
    .RAMP_TICKS(4)
  ) u_dut5 (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .i_btn    (btn5),
    .i_tick   (tick5),
    .i_halt   (halt5),
    .o_level  (lvl5),
    .o_target (tgt5),
    .o_ramping(ramp5),
    .o_halted (halted5)
  );

  speed_ramp_fsm #(
    .NUM_LEVELS(16),
    .RAMP_TICKS(1)
  ) u_dut16 (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .i_btn    (btn16),
    .i_tick   (tick16),
    .i_halt   (halt16),
    .o_level  (lvl16),
    .o_target (tgt16),
    .o_ramping(ramp16),
    .o_halted (halted16)
  );

  typedef struct {
    int    at;
    int    lvl;
    int    tgt;
    bit    ramp;
    bit    halt;
    string name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err = 0;

  function automatic void expect_at(int at, int lvl, int tgt, bit ramp, bit halt, string name);
    exp_t e;
    e.at = at; e.lvl = lvl; e.tgt = tgt; e.ramp = ramp; e.halt = halt; e.name = name;
    sb.push_back(e);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; btn5 = '0; tick5 = 1'b1; halt5 = 1'b0;
    btn16 = '0; tick16 = 1'b1; halt16 = 1'b0;
    #12;
    n_checks++;
    if ({lvl5, tgt5, ramp5, halted5} !== 8'b0) begin
      n_err++;
      $display("FAIL reset_hold: got lvl=%0d tgt=%0d ramp=%b halt=%b, expected all 0",
               lvl5, tgt5, ramp5, halted5);
    end
    n_checks++;
    if ({lvl16, tgt16, ramp16, halted16} !== 10'b0) begin
      n_err++;
      $display("FAIL reset_hold16: got lvl=%0d tgt=%0d ramp=%b halt=%b, expected all 0",
               lvl16, tgt16, ramp16, halted16);
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({lvl5, tgt5, ramp5, halted5} !== 8'b0) begin
      n_err++;
      $display("FAIL reset_release: got lvl=%0d tgt=%0d ramp=%b halt=%b, expected all 0",
               lvl5, tgt5, ramp5, halted5);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ramp_up();
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      int l;
      l = (k < 5) ? 0 : ((k - 1) / 4 > 3 ? 3 : (k - 1) / 4);
      expect_at(k, l, (k == 0) ? 0 : 3, (k >= 1 && k <= 12), 1'b0, "ramp_up");
    end
    for (int k = 0; k < 16; k++) begin
      btn5 = (k == 0) ? 5'b01000 : 5'b00000;
      @(negedge clk);
      while (sb.size() != 0 && sb[0].at == k) begin
        e = sb.pop_front();
        n_checks++;
        if (lvl5 !== 3'(e.lvl) || tgt5 !== 3'(e.tgt) || ramp5 !== e.ramp || halted5 !== e.halt) begin
          n_err++;
          $display("FAIL %s k=%0d: got lvl=%0d tgt=%0d ramp=%b halt=%b, expected lvl=%0d tgt=%0d ramp=%b halt=%b",
                   e.name, k, lvl5, tgt5, ramp5, halted5, e.lvl, e.tgt, e.ramp, e.halt);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority();
    exp_t e;
    expect_at(1, 3, 1, 1, 0, "prio_down");
    expect_at(5, 2, 1, 1, 0, "prio_down");
    expect_at(9, 1, 1, 0, 0, "prio_hold1");
    expect_at(11, 1, 2, 1, 0, "prio_multi");
    expect_at(15, 2, 2, 0, 0, "prio_multi");
    expect_at(17, 2, 4, 1, 0, "prio_held");
    expect_at(21, 3, 4, 1, 0, "prio_held");
    expect_at(25, 4, 4, 0, 0, "prio_held");
    expect_at(37, 4, 4, 0, 0, "prio_held_end");
    for (int k = 0; k < 38; k++) begin
      if (k == 0)                 btn5 = 5'b00010;
      else if (k == 10)           btn5 = 5'b10101;
      else if (k >= 16 && k < 36) btn5 = 5'b10000;
      else                        btn5 = 5'b00000;
      @(negedge clk);
      while (sb.size() != 0 && sb[0].at == k) begin
        e = sb.pop_front();
        n_checks++;
        if (lvl5 !== 3'(e.lvl) || tgt5 !== 3'(e.tgt) || ramp5 !== e.ramp || halted5 !== e.halt) begin
          n_err++;
          $display("FAIL %s k=%0d: got lvl=%0d tgt=%0d ramp=%b halt=%b, expected lvl=%0d tgt=%0d ramp=%b halt=%b",
                   e.name, k, lvl5, tgt5, ramp5, halted5, e.lvl, e.tgt, e.ramp, e.halt);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reversal();
    exp_t e;
    expect_at(1, 4, 1, 1, 0, "rev_down");
    expect_at(4, 4, 1, 1, 0, "rev_down");
    expect_at(5, 3, 1, 1, 0, "rev_step");
    expect_at(6, 3, 1, 1, 0, "rev_step");
    expect_at(7, 3, 3, 0, 0, "rev_retarget");
    expect_at(12, 3, 3, 0, 0, "rev_hold");
    for (int k = 0; k < 13; k++) begin
      btn5 = (k == 0) ? 5'b00010 : (k == 6) ? 5'b01000 : 5'b00000;
      @(negedge clk);
      while (sb.size() != 0 && sb[0].at == k) begin
        e = sb.pop_front();
        n_checks++;
        if (lvl5 !== 3'(e.lvl) || tgt5 !== 3'(e.tgt) || ramp5 !== e.ramp || halted5 !== e.halt) begin
          n_err++;
          $display("FAIL %s k=%0d: got lvl=%0d tgt=%0d ramp=%b halt=%b, expected lvl=%0d tgt=%0d ramp=%b halt=%b",
                   e.name, k, lvl5, tgt5, ramp5, halted5, e.lvl, e.tgt, e.ramp, e.halt);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    expect_at(1, 3, 1, 1, 0, "b2b_down");
    expect_at(5, 2, 1, 1, 0, "b2b_down");
    expect_at(9, 2, 1, 1, 0, "b2b_repress");
    expect_at(11, 2, 1, 1, 0, "b2b_repress");
    expect_at(12, 1, 1, 0, 0, "b2b_repress");
    expect_at(15, 1, 4, 1, 0, "b2b_up");
    expect_at(19, 1, 3, 1, 0, "b2b_step_vs_press");
    expect_at(23, 2, 3, 1, 0, "b2b_step_vs_press");
    expect_at(25, 2, 1, 1, 0, "b2b_reverse");
    expect_at(28, 2, 1, 1, 0, "b2b_reverse");
    expect_at(29, 1, 1, 0, 0, "b2b_reverse");
    for (int k = 0; k < 30; k++) begin
      case (k)
        0, 7, 24: btn5 = 5'b00010;
        14:       btn5 = 5'b10000;
        18:       btn5 = 5'b01000;
        default:  btn5 = 5'b00000;
      endcase
      @(negedge clk);
      while (sb.size() != 0 && sb[0].at == k) begin
        e = sb.pop_front();
        n_checks++;
        if (lvl5 !== 3'(e.lvl) || tgt5 !== 3'(e.tgt) || ramp5 !== e.ramp || halted5 !== e.halt) begin
          n_err++;
          $display("FAIL %s k=%0d: got lvl=%0d tgt=%0d ramp=%b halt=%b, expected lvl=%0d tgt=%0d ramp=%b halt=%b",
                   e.name, k, lvl5, tgt5, ramp5, halted5, e.lvl, e.tgt, e.ramp, e.halt);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    exp_t e;
    expect_at(1, 1, 4, 1, 0, "halt_pre");
    expect_at(5, 2, 4, 1, 0, "halt_pre");
    expect_at(6, 2, 4, 1, 0, "halt_assert");
    expect_at(7, 0, 0, 0, 1, "halt_enter");
    expect_at(8, 0, 0, 0, 1, "halt_press_ignored");
    expect_at(11, 0, 0, 0, 1, "halt_release");
    expect_at(12, 0, 0, 0, 0, "halt_idle");
    expect_at(14, 0, 3, 1, 0, "halt_after_press");
    expect_at(18, 1, 3, 1, 0, "halt_after_step");
    for (int k = 0; k < 19; k++) begin
      halt5 = (k >= 6 && k <= 10);
      btn5  = (k == 0) ? 5'b10000 : (k == 6) ? 5'b00100 : (k == 13) ? 5'b01000 : 5'b00000;
      @(negedge clk);
      while (sb.size() != 0 && sb[0].at == k) begin
        e = sb.pop_front();
        n_checks++;
        if (lvl5 !== 3'(e.lvl) || tgt5 !== 3'(e.tgt) || ramp5 !== e.ramp || halted5 !== e.halt) begin
          n_err++;
          $display("FAIL %s k=%0d: got lvl=%0d tgt=%0d ramp=%b halt=%b, expected lvl=%0d tgt=%0d ramp=%b halt=%b",
                   e.name, k, lvl5, tgt5, ramp5, halted5, e.lvl, e.tgt, e.ramp, e.halt);
        end
      end
      @(posedge clk); #1;
    end
    halt5 = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    expect_at(1, 1, 4, 1, 0, "areset_pre");
    expect_at(2, 1, 4, 1, 0, "areset_pre");
    for (int k = 0; k < 3; k++) begin
      btn5 = (k == 0) ? 5'b10000 : 5'b00000;
      @(negedge clk);
      while (sb.size() != 0 && sb[0].at == k) begin
        e = sb.pop_front();
        n_checks++;
        if (lvl5 !== 3'(e.lvl) || tgt5 !== 3'(e.tgt) || ramp5 !== e.ramp || halted5 !== e.halt) begin
          n_err++;
          $display("FAIL %s k=%0d: got lvl=%0d tgt=%0d ramp=%b halt=%b, expected lvl=%0d tgt=%0d ramp=%b halt=%b",
                   e.name, k, lvl5, tgt5, ramp5, halted5, e.lvl, e.tgt, e.ramp, e.halt);
        end
      end
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    btn5 = 5'b00100;
    #1;
    n_checks++;
    if ({lvl5, tgt5, ramp5, halted5} !== 8'b0) begin
      n_err++;
      $display("FAIL areset_immediate: got lvl=%0d tgt=%0d ramp=%b halt=%b, expected all 0",
               lvl5, tgt5, ramp5, halted5);
    end
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) expect_at(k, 0, 0, 0, 0, "areset_held_btn");
    for (int k = 0; k < 6; k++) begin
      btn5 = (k < 4) ? 5'b00100 : 5'b00000;
      @(negedge clk);
      while (sb.size() != 0 && sb[0].at == k) begin
        e = sb.pop_front();
        n_checks++;
        if (lvl5 !== 3'(e.lvl) || tgt5 !== 3'(e.tgt) || ramp5 !== e.ramp || halted5 !== e.halt) begin
          n_err++;
          $display("FAIL %s k=%0d: got lvl=%0d tgt=%0d ramp=%b halt=%b, expected lvl=%0d tgt=%0d ramp=%b halt=%b",
                   e.name, k, lvl5, tgt5, ramp5, halted5, e.lvl, e.tgt, e.ramp, e.halt);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // 16 levels, one step per tick: continuous ticks up and down, then ticks every 3rd cycle.
  task automatic test_sweep();
    exp_t e;
    for (int k = 1; k < 22; k++) begin
      int l;
      l = (k - 1 > 15) ? 15 : k - 1;
      expect_at(k, l, 15, (k < 16), 1'b0, "sweep_up");
    end
    for (int k = 22; k < 40; k++) begin
      int l;
      l = (15 - (k - 22) < 0) ? 0 : 15 - (k - 22);
      expect_at(k, l, 0, (k < 37), 1'b0, "sweep_down");
    end
    for (int k = 41; k < 90; k++) begin
      int l;
      l = ((k - 40) / 3 > 15) ? 15 : (k - 40) / 3;
      expect_at(k, l, 15, (l < 15), 1'b0, "sweep_sparse");
    end
    for (int k = 0; k < 90; k++) begin
      tick16 = (k < 40) ? 1'b1 : (k % 3 == 0);
      btn16  = (k == 0 || k == 40) ? 16'h8000 : (k == 21) ? 16'h0001 : 16'h0000;
      @(negedge clk);
      while (sb.size() != 0 && sb[0].at == k) begin
        e = sb.pop_front();
        n_checks++;
        if (lvl16 !== 4'(e.lvl) || tgt16 !== 4'(e.tgt) || ramp16 !== e.ramp ||
            halted16 !== e.halt) begin
          n_err++;
          $display("FAIL %s k=%0d: got lvl=%0d tgt=%0d ramp=%b halt=%b, expected lvl=%0d tgt=%0d ramp=%b halt=%b",
                   e.name, k, lvl16, tgt16, ramp16, halted16, e.lvl, e.tgt, e.ramp, e.halt);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ramp_up();
    test_priority();
    test_reversal();
    test_back_to_back();
    test_halt();
    test_async_reset();
    test_sweep();
    if (sb.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d expectations never reached, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
